// File: rtl/phv_pkt_merger.sv
// Header merger: rewrites the leading bytes of each buffered packet with PHV header
// bytes, or forwards / drops the packet, behind a registered AXI-Stream output stage.
module phv_pkt_merger #(
  parameter int DATA_WIDTH    = 256,
  parameter int TUSER_WIDTH   = 128,
  parameter int HDR_SEGS      = 4,
  parameter int LEN_WIDTH     = 8,
  parameter int PKT_FIFO_BITS = 6,
  parameter int PHV_FIFO_BITS = 4
) (
  input  logic                           CLK_156,
  input  logic                           ARESETN_156,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]         s_axis_tuser,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [HDR_SEGS*DATA_WIDTH-1:0] s_phv_hdr,
  input  logic [LEN_WIDTH-1:0]           s_phv_len,
  input  logic                           s_phv_drop,
  input  logic                           s_phv_valid,
  output logic                           s_phv_ready,
  input  logic                           ctrl_bypass,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]        m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]         m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [31:0]                    stat_pkt_cnt,
  output logic [31:0]                    stat_drop_cnt
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int HDR_W     = HDR_SEGS * DATA_WIDTH;
  localparam int HDR_BYTES = HDR_SEGS * BYTES;
  localparam int PKT_W     = DATA_WIDTH + TUSER_WIDTH + BYTES + 1;
  localparam int PHV_W     = HDR_W + LEN_WIDTH + 1;
  localparam int PKT_DEPTH = 1 << PKT_FIFO_BITS;
  localparam int PHV_DEPTH = 1 << PHV_FIFO_BITS;
  localparam int BCNT_W    = $clog2(HDR_SEGS + 1);

  localparam logic [PKT_FIFO_BITS-1:0] PKT_PTR_ONE = 1;
  localparam logic [PKT_FIFO_BITS:0]   PKT_CNT_ONE = 1;
  localparam logic [PKT_FIFO_BITS:0]   PKT_RDY_MAX = (PKT_FIFO_BITS+1)'(PKT_DEPTH - 2);
  localparam logic [PHV_FIFO_BITS-1:0] PHV_PTR_ONE = 1;
  localparam logic [PHV_FIFO_BITS:0]   PHV_CNT_ONE = 1;
  localparam logic [PHV_FIFO_BITS:0]   PHV_FULL    = (PHV_FIFO_BITS+1)'(PHV_DEPTH);
  localparam logic [BCNT_W-1:0]        BCNT_MAX    = BCNT_W'(HDR_SEGS);
  localparam logic [BCNT_W-1:0]        BCNT_ONE    = 1;
  localparam logic [LEN_WIDTH-1:0]     LEN_CAP     = LEN_WIDTH'(HDR_BYTES);

  typedef enum logic [1:0] {IDLE, MERGE, PASS, DROP} state_t;

  state_t state_q;

  // ---------------- packet FIFO (fall-through) ----------------
  logic [PKT_W-1:0]         pkt_mem [PKT_DEPTH];
  logic [PKT_FIFO_BITS-1:0] pkt_wp_q, pkt_rp_q;
  logic [PKT_FIFO_BITS:0]   pkt_cnt_q, pkt_cnt_d;
  logic                     pkt_rdy_q, pkt_wr, pkt_rd, pkt_empty;
  logic [DATA_WIDTH-1:0]    head_data;
  logic [TUSER_WIDTH-1:0]   head_user;
  logic [BYTES-1:0]         head_keep;
  logic                     head_last;

  assign pkt_wr    = s_axis_tvalid && pkt_rdy_q;
  assign pkt_empty = (pkt_cnt_q == '0);
  assign {head_data, head_user, head_keep, head_last} = pkt_mem[pkt_rp_q];

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_wr && !pkt_rd)      pkt_cnt_d = pkt_cnt_q + PKT_CNT_ONE;
    else if (!pkt_wr && pkt_rd) pkt_cnt_d = pkt_cnt_q - PKT_CNT_ONE;
  end

  always_ff @(posedge CLK_156) begin
    if (pkt_wr) pkt_mem[pkt_wp_q] <= {s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast};
  end

  // Ready is registered from the next occupancy so it is low during reset.
  always_ff @(posedge CLK_156 or negedge ARESETN_156) begin
    if (!ARESETN_156) begin
      pkt_wp_q  <= '0;
      pkt_rp_q  <= '0;
      pkt_cnt_q <= '0;
      pkt_rdy_q <= 1'b0;
    end else begin
      if (pkt_wr) pkt_wp_q <= pkt_wp_q + PKT_PTR_ONE;
      if (pkt_rd) pkt_rp_q <= pkt_rp_q + PKT_PTR_ONE;
      pkt_cnt_q <= pkt_cnt_d;
      pkt_rdy_q <= (pkt_cnt_d <= PKT_RDY_MAX);
    end
  end

  // ---------------- PHV FIFO (fall-through) ----------------
  logic [PHV_W-1:0]         phv_mem [PHV_DEPTH];
  logic [PHV_FIFO_BITS-1:0] phv_wp_q, phv_rp_q;
  logic [PHV_FIFO_BITS:0]   phv_cnt_q, phv_cnt_d;
  logic                     phv_rdy_q, phv_wr, phv_rd, phv_empty;
  logic [HDR_W-1:0]         phv_hdr;
  logic [LEN_WIDTH-1:0]     phv_len;
  logic                     phv_drop;

  assign phv_wr    = s_phv_valid && phv_rdy_q;
  assign phv_empty = (phv_cnt_q == '0);
  assign {phv_hdr, phv_len, phv_drop} = phv_mem[phv_rp_q];

  always_comb begin
    phv_cnt_d = phv_cnt_q;
    if (phv_wr && !phv_rd)      phv_cnt_d = phv_cnt_q + PHV_CNT_ONE;
    else if (!phv_wr && phv_rd) phv_cnt_d = phv_cnt_q - PHV_CNT_ONE;
  end

  always_ff @(posedge CLK_156) begin
    if (phv_wr) phv_mem[phv_wp_q] <= {s_phv_hdr, s_phv_len, s_phv_drop};
  end

  always_ff @(posedge CLK_156 or negedge ARESETN_156) begin
    if (!ARESETN_156) begin
      phv_wp_q  <= '0;
      phv_rp_q  <= '0;
      phv_cnt_q <= '0;
      phv_rdy_q <= 1'b0;
    end else begin
      if (phv_wr) phv_wp_q <= phv_wp_q + PHV_PTR_ONE;
      if (phv_rd) phv_rp_q <= phv_rp_q + PHV_PTR_ONE;
      phv_cnt_q <= phv_cnt_d;
      phv_rdy_q <= (phv_cnt_d != PHV_FULL);
    end
  end

  // ---------------- header merge datapath ----------------
  logic [BCNT_W-1:0]      bcnt_q;
  logic [LEN_WIDTH-1:0]   lc;
  logic [DATA_WIDTH-1:0]  hdr_seg, merged;
  logic                   seg_live;
  int                     seg_base;

  always_comb begin
    lc       = (phv_len > LEN_CAP) ? LEN_CAP : phv_len;
    seg_live = (state_q == MERGE) && (bcnt_q < BCNT_MAX);
    seg_base = seg_live ? int'(bcnt_q) * DATA_WIDTH : 0;
    hdr_seg  = phv_hdr[seg_base +: DATA_WIDTH];
  end

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte
      logic [31:0] pos;
      assign pos = 32'(bcnt_q) * 32'(BYTES) + 32'(gi);
      assign merged[gi*8 +: 8] = (seg_live && pos < 32'(lc)) ? hdr_seg[gi*8 +: 8]
                                                              : head_data[gi*8 +: 8];
    end
  endgenerate

  // ---------------- control FSM and registered output stage ----------------
  logic                   m_tvalid_q, m_tlast_q, out_free;
  logic [DATA_WIDTH-1:0]  m_tdata_q;
  logic [BYTES-1:0]       m_tkeep_q;
  logic [TUSER_WIDTH-1:0] m_tuser_q;
  logic [31:0]            stat_pkt_q, stat_drop_q;

  always_comb begin
    out_free = !m_tvalid_q || m_axis_tready;
    pkt_rd   = 1'b0;
    case (state_q)
      MERGE, PASS: pkt_rd = !pkt_empty && out_free;
      DROP:        pkt_rd = !pkt_empty;
      default:     pkt_rd = 1'b0;
    endcase
    phv_rd = pkt_rd && head_last && (state_q == MERGE || state_q == DROP);
  end

  always_ff @(posedge CLK_156 or negedge ARESETN_156) begin
    if (!ARESETN_156) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tuser_q   <= '0;
      m_tlast_q   <= 1'b0;
      stat_pkt_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      if (m_tvalid_q && m_axis_tready) begin
        m_tvalid_q <= 1'b0;
        if (m_tlast_q) stat_pkt_q <= stat_pkt_q + 32'd1;
      end
      case (state_q)
        IDLE: begin
          bcnt_q <= '0;
          if (!pkt_empty) begin
            if (ctrl_bypass)     state_q <= PASS;
            else if (!phv_empty) state_q <= phv_drop ? DROP : MERGE;
          end
        end
        MERGE, PASS: begin
          if (pkt_rd) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= merged;
            m_tkeep_q  <= head_keep;
            m_tuser_q  <= head_user;
            m_tlast_q  <= head_last;
            if (head_last) begin
              state_q <= IDLE;
              bcnt_q  <= '0;
            end else if (bcnt_q != BCNT_MAX) begin
              bcnt_q <= bcnt_q + BCNT_ONE;
            end
          end
        end
        DROP: begin
          if (pkt_rd && head_last) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            stat_drop_q <= stat_drop_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_axis_tready = pkt_rdy_q;
  assign s_phv_ready   = phv_rdy_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tlast  = m_tlast_q;
  assign stat_pkt_cnt  = stat_pkt_q;
  assign stat_drop_cnt = stat_drop_q;

endmodule

// File: tb/tb_phv_pkt_merger.sv
// Randomised and directed bench for phv_pkt_merger; expected beats come from a
// byte-level reference model built when each packet is queued.
module tb_phv_pkt_merger;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;
  localparam int HS = 4;
  localparam int HW = HS * DW;
  localparam int CAP = HS * KW;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    logic [HW-1:0] h;
    logic [7:0]    len;
    logic          drop;
  } phv_t;

  logic          clk;
  logic          ARESETN;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [HW-1:0] s_phv_hdr;
  logic [7:0]    s_phv_len;
  logic          s_phv_drop, s_phv_valid, s_phv_ready;
  logic          ctrl_bypass;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [31:0]   stat_pkt_cnt, stat_drop_cnt;

  phv_pkt_merger #(
    .DATA_WIDTH(DW), .TUSER_WIDTH(UW), .HDR_SEGS(HS), .LEN_WIDTH(8),
    .PKT_FIFO_BITS(3), .PHV_FIFO_BITS(2)
  ) dut (
    .CLK_156(clk), .ARESETN_156(ARESETN),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_phv_hdr(s_phv_hdr), .s_phv_len(s_phv_len), .s_phv_drop(s_phv_drop),
    .s_phv_valid(s_phv_valid), .s_phv_ready(s_phv_ready), .ctrl_bypass(ctrl_bypass),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    n_vec = 0;
  int    n_err = 0;
  int    out_beats = 0;
  int    exp_pkts = 0;
  int    exp_drops = 0;
  int    rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  bit    abort = 1'b0;
  beat_t in_q[$];
  beat_t exp_q[$];
  phv_t  phv_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Queue one packet and its PHV, and derive the expected output from byte positions.
  task automatic add_pkt(input int nb, input int len, input bit drop, input bit byp,
                         input bit seq, input bit hdr_aa);
    beat_t b;
    beat_t e;
    phv_t  p;
    int    lc;
    int    pos;
    int    nkeep;
    for (int i = 0; i < CAP; i++) p.h[i*8 +: 8] = hdr_aa ? 8'hAA : 8'($urandom);
    p.len  = 8'(len);
    p.drop = drop;
    if (!byp) phv_q.push_back(p);
    lc = (len < CAP) ? len : CAP;
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < KW; i++) b.d[i*8 +: 8] = seq ? 8'(k*KW + i) : 8'($urandom);
      b.u = {$urandom, $urandom, $urandom, $urandom};
      b.l = (k == nb - 1);
      nkeep = (b.l && !seq) ? int'($urandom_range(KW, 1)) : KW;
      b.k = (nkeep == KW) ? '1 : KW'((33'd1 << nkeep) - 33'd1);
      in_q.push_back(b);
      if (byp || !drop) begin
        e = b;
        if (!byp) begin
          for (int i = 0; i < KW; i++) begin
            pos = k*KW + i;
            if (pos < lc) e.d[i*8 +: 8] = p.h[pos*8 +: 8];
          end
        end
        exp_q.push_back(e);
      end
    end
    if (drop && !byp) exp_drops++;
    else exp_pkts++;
  endtask

  // Both drivers are entered on a falling edge; a beat offered while ready is
  // high is taken at the next rising edge.
  task automatic drive_pkts();
    int guard = 0;
    while (in_q.size() > 0 && !abort) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = in_q[0].d;
      s_axis_tkeep  = in_q[0].k;
      s_axis_tuser  = in_q[0].u;
      s_axis_tlast  = in_q[0].l;
      if (s_axis_tready) void'(in_q.pop_front());
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        chk("pkt_drv_timeout", DW'(1), DW'(0));
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drive_phvs();
    int guard = 0;
    while (phv_q.size() > 0 && !abort) begin
      s_phv_valid = 1'b1;
      s_phv_hdr   = phv_q[0].h;
      s_phv_len   = phv_q[0].len;
      s_phv_drop  = phv_q[0].drop;
      if (s_phv_ready) void'(phv_q.pop_front());
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        chk("phv_drv_timeout", DW'(1), DW'(0));
        break;
      end
    end
    s_phv_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", DW'(1), DW'(0));
    repeat (12) @(negedge clk);
  endtask

  task automatic run();
    fork
      drive_pkts();
      drive_phvs();
    join
    wait_drain();
  endtask

  task automatic wait_first_beat();
    int start = out_beats;
    int n = 0;
    while (out_beats == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("first_beat_timeout", DW'(1), DW'(0));
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_pkt_cnt"}, DW'(stat_pkt_cnt), DW'(exp_pkts));
    chk({tag, "_drop_cnt"}, DW'(stat_drop_cnt), DW'(exp_drops));
  endtask

  // Output monitor and sink: ready is changed on the falling edge, so a
  // valid&ready seen here is the handshake of the coming rising edge.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_d;
    logic [KW-1:0] prev_k;
    beat_t         e;
    prev_stall    = 1'b0;
    prev_d        = '0;
    prev_k        = '0;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(3, 0) != 0);
        default: m_axis_tready = 1'b0;
      endcase
      if (!ARESETN) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_tvalid", DW'(m_axis_tvalid), DW'(1));
          chk("hold_tdata", m_axis_tdata, prev_d);
          chk("hold_tkeep", DW'(m_axis_tkeep), DW'(prev_k));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          out_beats++;
          if (exp_q.size() == 0) begin
            chk("extra_beat", DW'(1), DW'(0));
          end else begin
            e = exp_q.pop_front();
            chk("tdata", m_axis_tdata, e.d);
            chk("tkeep", DW'(m_axis_tkeep), DW'(e.k));
            chk("tuser", DW'(m_axis_tuser), DW'(e.u));
            chk("tlast", DW'(m_axis_tlast), DW'(e.l));
            $display("beat %0d data[63:0]=%h keep=%h last=%0d", out_beats,
                     m_axis_tdata[63:0], m_axis_tkeep, m_axis_tlast);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_d     = m_axis_tdata;
        prev_k     = m_axis_tkeep;
      end
    end
  end

  initial begin
    ARESETN       = 1'b1;
    ctrl_bypass   = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    s_phv_valid   = 1'b0;
    s_phv_hdr     = '0;
    s_phv_len     = '0;
    s_phv_drop    = 1'b0;
    #1 ARESETN = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_tready", DW'(s_axis_tready), DW'(0));
    chk("rst_phv_ready", DW'(s_phv_ready), DW'(0));
    chk("rst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("rst_m_tdata", m_axis_tdata, DW'(0));
    chk_stats("rst");
    ARESETN = 1'b1;
    @(negedge clk);
    chk("rel_s_tready", DW'(s_axis_tready), DW'(1));
    chk("rel_phv_ready", DW'(s_phv_ready), DW'(1));

    // 3-beat sequential packet, 40 header bytes of 0xAA
    add_pkt(3, 40, 1'b0, 1'b0, 1'b1, 1'b1);
    run();
    chk_stats("s1");

    // length beyond the 128-byte cap on a 6-beat packet
    add_pkt(6, 200, 1'b0, 1'b0, 1'b1, 1'b0);
    run();
    chk_stats("s2");

    // dropped 2-beat packet followed by a normal one
    add_pkt(2, 50, 1'b1, 1'b0, 1'b0, 1'b0);
    add_pkt(3, 30, 1'b0, 1'b0, 1'b0, 1'b0);
    run();
    chk_stats("s3");
    chk("s3_phv_ready", DW'(s_phv_ready), DW'(1));

    // bypass with no PHV queued
    ctrl_bypass = 1'b1;
    add_pkt(3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run();
    chk_stats("s4a");

    // bypass with a drop PHV waiting; bypass drops mid-packet
    add_pkt(4, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_pkt(3, 60, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_phvs();
    fork
      drive_pkts();
      begin
        wait_first_beat();
        ctrl_bypass = 1'b0;
      end
    join
    wait_drain();
    chk_stats("s4b");

    // output stalled for 10 cycles mid-packet
    add_pkt(12, 100, 1'b0, 1'b0, 1'b0, 1'b0);
    fork
      drive_pkts();
      drive_phvs();
      begin
        wait_first_beat();
        rdy_mode = 2;
        repeat (10) @(negedge clk);
        chk("stall_s_tready", DW'(s_axis_tready), DW'(0));
        rdy_mode = 0;
      end
    join
    wait_drain();
    chk_stats("s5");

    // reset pulse in the middle of a stalled packet
    rdy_mode = 2;
    add_pkt(10, 64, 1'b0, 1'b0, 1'b0, 1'b0);
    fork
      drive_pkts();
      drive_phvs();
      begin
        repeat (15) @(negedge clk);
        chk("pre_rst_tvalid", DW'(m_axis_tvalid), DW'(1));
        #2;
        abort   = 1'b1;
        ARESETN = 1'b0;
        #1;
        chk("midrst_m_tvalid", DW'(m_axis_tvalid), DW'(0));
        chk("midrst_m_tdata", m_axis_tdata, DW'(0));
        chk("midrst_s_tready", DW'(s_axis_tready), DW'(0));
        chk("midrst_phv_ready", DW'(s_phv_ready), DW'(0));
        chk("midrst_pkt_cnt", DW'(stat_pkt_cnt), DW'(0));
        chk("midrst_drop_cnt", DW'(stat_drop_cnt), DW'(0));
      end
    join
    in_q.delete();
    phv_q.delete();
    exp_q.delete();
    exp_pkts  = 0;
    exp_drops = 0;
    @(negedge clk);
    ARESETN  = 1'b1;
    abort    = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    chk("post_rst_s_tready", DW'(s_axis_tready), DW'(1));
    add_pkt(3, 40, 1'b0, 1'b0, 1'b1, 1'b1);
    run();
    chk_stats("s6");

    // randomised traffic with random backpressure
    rdy_mode = 1;
    for (int p = 0; p < 30; p++) begin
      add_pkt(int'($urandom_range(6, 1)), int'($urandom_range(255, 0)),
              ($urandom_range(4, 0) == 0), 1'b0, 1'b0, 1'b0);
    end
    run();
    rdy_mode = 0;
    chk_stats("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/phv_pkt_merger.md
PHV_PKT_MERGER -- requirements
Module: phv_pkt_merger

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- DATA_WIDTH, 256: AXIS data width in bits; multiple of 64.
- TUSER_WIDTH, 128: AXIS tuser width in bits.
- HDR_SEGS, 4: maximum number of header beats that can be replaced.
- LEN_WIDTH, 8: width of header byte length; 2^LEN_WIDTH SHALL be greater than HDR_SEGS*DATA_WIDTH/8.
- PKT_FIFO_BITS, 6: log2 of the packet FIFO depth.
- PHV_FIFO_BITS, 4: log2 of the PHV FIFO depth.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning; clock and reset first):
- CLK_156, in, 1: single clock.
- ARESETN_156, in, 1: reset, asynchronous, active-low.
- s_axis_tdata, in, DATA_WIDTH: packet beat.
- s_axis_tkeep, in, DATA_WIDTH/8: byte enables.
- s_axis_tuser, in, TUSER_WIDTH: sideband.
- s_axis_tvalid, in, 1.
- s_axis_tready, out, 1.
- s_axis_tlast, in, 1.
- s_phv_hdr, in, HDR_SEGS*DATA_WIDTH: rewritten header bytes.
- s_phv_len, in, LEN_WIDTH: number of leading packet bytes to replace.
- s_phv_drop, in, 1: discard the packet.
- s_phv_valid, in, 1.
- s_phv_ready, out, 1.
- ctrl_bypass, in, 1: pass packets unmodified without consuming a PHV.
- m_axis_tdata, out, DATA_WIDTH.
- m_axis_tkeep, out, DATA_WIDTH/8.
- m_axis_tuser, out, TUSER_WIDTH.
- m_axis_tvalid, out, 1.
- m_axis_tready, in, 1.
- m_axis_tlast, out, 1.
- stat_pkt_cnt, out, 32: count of packets emitted.
- stat_drop_cnt, out, 32: count of packets dropped.

Function
REQ-003 SHALL buffer input beats {tdata, tuser, tkeep, tlast} in a fall-through FIFO of 2^PKT_FIFO_BITS entries.
REQ-004 SHALL drive s_axis_tready = 1 while at least 2 FIFO entries are free, and write a beat only on s_axis_tvalid & s_axis_tready.
REQ-005 SHALL buffer {hdr, len, drop} in a FIFO of 2^PHV_FIFO_BITS entries, with s_phv_ready = !full and a write on s_phv_valid & s_phv_ready.
REQ-006 SHALL use byte i = tdata[8i+:8]; beat k of a packet covers packet bytes k*DATA_WIDTH/8 onward.
REQ-007 SHALL use a control FSM with states IDLE, MERGE, PASS, DROP.
REQ-008 In IDLE, with the packet FIFO non-empty, the FSM SHALL sample ctrl_bypass; if 1, go to PASS.
- Otherwise, if the PHV FIFO is non-empty, go to DROP if drop=1, else MERGE.
- Otherwise remain in IDLE.
- The decision takes 1 cycle; no beat is popped in IDLE.
REQ-009 In MERGE, output byte i of beat k SHALL be s_phv_hdr byte (k*DATA_WIDTH/8+i) when k<HDR_SEGS and the byte index < Lc; otherwise it SHALL be the packet byte.
- Lc = min(len, HDR_SEGS*DATA_WIDTH/8).
REQ-010 SHALL saturate the beat counter at HDR_SEGS and clear it on IDLE entry.
REQ-011 SHALL pass tkeep, tuser and tlast through unchanged from the packet beat in all modes; header bytes beyond the packet length are written to tdata but tkeep is not extended.
REQ-012 In PASS, SHALL forward beats unmodified and SHALL NOT pop the PHV FIFO.
REQ-013 In MERGE and PASS, SHALL pop one beat per cycle only when the output register is empty or m_axis_tready=1.
REQ-014 SHALL register the output stage, giving 1 cycle from FIFO pop to m_axis_tvalid; m_axis_* SHALL hold stable while tvalid & !tready.
REQ-015 In DROP, SHALL pop one beat per cycle regardless of m_axis_tready and emit nothing.
REQ-016 SHALL pop the PHV entry in MERGE or DROP on the same cycle the tlast beat is popped, then return to IDLE.
REQ-017 SHALL increment stat_pkt_cnt when m_axis_tvalid & m_axis_tready & m_axis_tlast, and stat_drop_cnt when the DROP tlast beat is popped; both wrap modulo 2^32.
REQ-018 ctrl_bypass changes mid-packet SHALL have no effect until the next IDLE decision.
REQ-019 A PHV write and PHV pop in the same cycle SHALL both take effect; the same SHALL hold for the packet FIFO.

Reset
REQ-020 While ARESETN_156=0, asynchronously: state=IDLE; beat counter, FIFOs, stat counters=0; m_axis_tvalid=0; m_axis_tdata/tkeep/tuser/tlast=0; s_axis_tready=0; s_phv_ready=0.
REQ-021 A reset asserted mid-packet SHALL discard all buffered beats and PHVs.
REQ-022 s_axis_tready and s_phv_ready SHALL rise on the first clock edge after ARESETN_156 deasserts.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- 3-beat packet, bytes 0x00..0x5F, len=40, hdr bytes=0xAA -> beat0 all 0xAA; beat1 bytes 0-7 0xAA, bytes 8-31 original; beat2 original; stat_pkt_cnt=1.
- len=200, HDR_SEGS=4 (128-byte cap), 6-beat packet -> beats 0-3 fully header, beats 4-5 original.
- drop=1 on a 2-beat packet followed by a normal packet -> only the second packet emitted; stat_drop_cnt=1; PHV FIFO empty after.
- ctrl_bypass=1 with no PHV queued -> packet emitted unmodified; PHV FIFO untouched; toggling bypass mid-packet has no effect.
- m_axis_tready held at 0 for 10 cycles mid-packet -> output held stable; s_axis_tready falls when 2 entries remain; no beat lost or duplicated.
- ARESETN_156 pulsed low mid-packet -> m_axis_tvalid=0 immediately, counters=0; next packet merges correctly.
